// File: rtl/kan_array_scheduler.sv
// ---------------------------------------------------------------------------
// kan_array_scheduler
//
// Purpose: sequences a square PE array of a KAN accelerator through three
// phases:
//   - streaming coefficients into every PE,
//   - enabling the array for a compute run of programmable length,
//   - waiting for the array outputs to settle.
//
// Ports:
//   clk, rst_n            - single clock; asynchronous active-low reset
//   load_start            - pulse, starts a coefficient load (IDLE only)
//   run_start, run_len    - pulse plus enable-cycle count, starts a run (IDLE only)
//   cfg_valid/cfg_ready   - coefficient stream handshake
//   cfg_data              - coefficient word
//   arr_coeff_we          - one-hot PE write strobe, bit row*ARRAY_SIZE+col
//   arr_coeff_addr/_data  - coefficient address/word broadcast to all PEs
//   arr_enable            - array compute enable
//   arr_valid_all         - AND of all PE output_valid flags
//   busy, done, error     - status; done and error are one-cycle pulses
//   abort                 - only present when KAN_SCHED_ABORT_EN is defined
//
// Optional feature macro: KAN_SCHED_ABORT_EN (adds the abort input).
// ---------------------------------------------------------------------------
module kan_array_scheduler #(
  parameter int ARRAY_SIZE    = 8,
  parameter int COEFF_WIDTH   = 16,
  parameter int COEFF_DEPTH   = 64,
  parameter int DRAIN_TIMEOUT = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_start,
  input  logic                             run_start,
  input  logic [15:0]                      run_len,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [COEFF_WIDTH-1:0]           cfg_data,
`ifdef KAN_SCHED_ABORT_EN
  input  logic                             abort,
`endif
  output logic [ARRAY_SIZE*ARRAY_SIZE-1:0] arr_coeff_we,
  output logic [8:0]                       arr_coeff_addr,
  output logic [COEFF_WIDTH-1:0]           arr_coeff_data,
  output logic                             arr_enable,
  input  logic                             arr_valid_all,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int NPE  = ARRAY_SIZE * ARRAY_SIZE;
  localparam int PE_W = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int DR_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;

  state_e                 state_q, state_d;
  // Flat PE index: row*ARRAY_SIZE+col, so incrementing it walks col then row.
  logic [PE_W-1:0]        pe_q, pe_d;
  logic [8:0]             addr_q, addr_d;
  logic                   loaded_q, loaded_d;
  logic [15:0]            run_cnt_q, run_cnt_d;
  logic [DR_W-1:0]        drain_q, drain_d;
  logic [NPE-1:0]         we_q, we_d;
  logic [8:0]             addr_out_q, addr_out_d;
  logic [COEFF_WIDTH-1:0] data_q, data_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   abort_hit;

`ifdef KAN_SCHED_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pe_d       = pe_q;
    addr_d     = addr_q;
    loaded_d   = loaded_q;
    run_cnt_d  = run_cnt_q;
    drain_d    = drain_q;
    we_d       = '0;
    addr_out_d = addr_out_q;
    data_d     = data_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    if (abort_hit) begin
      state_d = IDLE;
      error_d = 1'b1;
      drain_d = '0;
      if (state_q == LOAD) begin
        loaded_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          // Load takes priority when both commands arrive together.
          if (load_start) begin
            state_d  = LOAD;
            pe_d     = '0;
            addr_d   = '0;
            loaded_d = 1'b0;
          end else if (run_start) begin
            if (!loaded_q || (run_len == 16'd0)) begin
              error_d = 1'b1;
            end else begin
              state_d   = RUN;
              run_cnt_d = run_len;
            end
          end
        end

        LOAD: begin
          if (cfg_valid) begin
            we_d       = NPE'(1) << pe_q;
            addr_out_d = addr_q;
            data_d     = cfg_data;
            if (addr_q == 9'(COEFF_DEPTH - 1)) begin
              addr_d = '0;
              if (pe_q == PE_W'(NPE - 1)) begin
                // Last word of the whole array: the strobe and done issue
                // together on the next cycle, with cfg_ready already low.
                pe_d     = '0;
                loaded_d = 1'b1;
                done_d   = 1'b1;
                state_d  = IDLE;
              end else begin
                pe_d = pe_q + 1'b1;
              end
            end else begin
              addr_d = addr_q + 9'd1;
            end
          end
        end

        RUN: begin
          if (run_cnt_q == 16'd1) begin
            state_d   = DRAIN;
            run_cnt_d = '0;
            drain_d   = '0;
          end else begin
            run_cnt_d = run_cnt_q - 16'd1;
          end
        end

        DRAIN: begin
          if (arr_valid_all) begin
            done_d  = 1'b1;
            state_d = IDLE;
            drain_d = '0;
          end else if (drain_q == DR_W'(DRAIN_TIMEOUT - 1)) begin
            error_d = 1'b1;
            state_d = IDLE;
            drain_d = '0;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pe_q       <= '0;
      addr_q     <= '0;
      loaded_q   <= 1'b0;
      run_cnt_q  <= '0;
      drain_q    <= '0;
      we_q       <= '0;
      addr_out_q <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pe_q       <= pe_d;
      addr_q     <= addr_d;
      loaded_q   <= loaded_d;
      run_cnt_q  <= run_cnt_d;
      drain_q    <= drain_d;
      we_q       <= we_d;
      addr_out_q <= addr_out_d;
      data_q     <= data_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign cfg_ready      = (state_q == LOAD);
  assign arr_enable     = (state_q == RUN);
  assign busy           = (state_q != IDLE);
  assign arr_coeff_we   = we_q;
  assign arr_coeff_addr = addr_out_q;
  assign arr_coeff_data = data_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: doc/kan_array_scheduler.md
KAN_ARRAY_SCHEDULER -- requirements
Module: kan_array_scheduler

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8, PE array rows/cols.
REQ-002 SHALL have parameter COEFF_WIDTH, default 16, coefficient word width.
REQ-003 SHALL have parameter COEFF_DEPTH, default 64, coefficients per PE (max 512).
REQ-004 SHALL have parameter DRAIN_TIMEOUT, default 32, max cycles waiting for array outputs.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port load_start  input  1  pulse: begin coefficient load.
REQ-008 SHALL have port run_start  input  1  pulse: begin compute run.
REQ-009 SHALL have port run_len  input  16  enable cycles per run, sampled at run_start.
REQ-010 SHALL have port cfg_valid / cfg_ready  input / output  1 / 1  coefficient stream handshake.
REQ-011 SHALL have port cfg_data  input  COEFF_WIDTH  coefficient word.
REQ-012 SHALL have port arr_coeff_we  output  ARRAY_SIZE*ARRAY_SIZE  one-hot PE write strobe, bit row*ARRAY_SIZE+col.
REQ-013 SHALL have port arr_coeff_addr / arr_coeff_data  output  9 / COEFF_WIDTH  broadcast to all PEs.
REQ-014 SHALL have port arr_enable  output  1  array enable.
REQ-015 SHALL have port arr_valid_all  input  1  AND of all PE output_valid.
REQ-016 SHALL have port busy / done / error  output  1 each  status; done, error are 1-cycle pulses.

Function
REQ-017 FSM states IDLE, LOAD, RUN, DRAIN; start commands honoured only in IDLE, ignored elsewhere.
REQ-018 IDLE: load_start -> LOAD, counters cleared, loaded flag cleared; load_start and run_start same cycle -> load wins, run dropped.
REQ-019 IDLE: run_start with loaded flag clear or run_len=0 -> error pulse next cycle, stay IDLE.
REQ-020 LOAD: cfg_ready=1; each cfg_valid&&cfg_ready transfer registers one write: next cycle exactly one arr_coeff_we bit high, addr/data valid same cycle.
REQ-021 Load order: addr 0..COEFF_DEPTH-1 innermost, then col 0..ARRAY_SIZE-1, then row; addr wraps to 0 on col increment, col wraps on row increment.
REQ-022 After word ARRAY_SIZE*ARRAY_SIZE*COEFF_DEPTH accepted: cfg_ready drops same cycle the last write strobe issues, loaded flag set, done pulse, -> IDLE.
REQ-023 cfg_valid low in LOAD stalls without timeout; arr_coeff_we all-zero on stall cycles.
REQ-024 RUN: arr_enable=1 for exactly run_len consecutive cycles starting cycle after run_start; then -> DRAIN.
REQ-025 DRAIN: arr_enable=0; arr_valid_all=1 -> done pulse, -> IDLE; DRAIN_TIMEOUT cycles without it -> error pulse, -> IDLE.
REQ-026 busy=1 in LOAD, RUN, DRAIN; 0 in IDLE.
REQ-027 arr_coeff_we never asserted outside LOAD; arr_enable never asserted outside RUN.

Reset
REQ-028 rst_n low asynchronously forces IDLE; busy, done, error, cfg_ready, arr_enable, arr_coeff_we = 0; addr/data = 0; counters and loaded flag = 0.
REQ-029 Reset mid-LOAD discards partial load; a fresh full load required before run.
REQ-030 First state change only on first rising clk edge after rst_n deasserts.

Configuration
REQ-031 Macro KAN_SCHED_ABORT_EN defined: input port abort (1 bit) present; abort=1 in any non-IDLE state -> IDLE next cycle, arr_enable and arr_coeff_we low that cycle, error pulse, loaded flag cleared if aborted in LOAD.
REQ-032 Macro undefined: no abort port; FSM leaves LOAD/RUN/DRAIN only per REQ-022/024/025.

Verification
REQ-033 ARRAY_SIZE=2, COEFF_DEPTH=4, stream 16 words 0x0100..0x010F back-to-back -> we bits 0,0,0,0,1,1,1,1,2..3 with addr 0..3 repeating, data matching, done after 16th.
REQ-034 Same load with cfg_valid toggled every other cycle -> identical write sequence, zero we on gaps, no lost/duplicated words.
REQ-035 Loaded, run_len=5, arr_valid_all high 3 cycles after enable drops -> arr_enable high exactly 5 cycles, done pulse once, busy low after.
REQ-036 run_start before any load, and run_len=0 after load -> error pulse each, arr_enable never high.
REQ-037 DRAIN with arr_valid_all held low -> error pulse exactly DRAIN_TIMEOUT (32) cycles after entering DRAIN.
REQ-038 rst_n low after 7 of 16 load words -> outputs zero immediately, then run_start -> error; with KAN_SCHED_ABORT_EN, abort in RUN -> arr_enable low next cycle, error pulse.
